seg7_scan_capture: RTL
======================

// Module: seg7_scan_capture
// PURPOSE
//  Receive end of the multiplexed 7-segment display bus: samples active-low segment lines and active-low digit enables,
//  converts each stable segment pattern back to a BCD digit plus decimal point, and assembles a full frame of digits.
//  Sits between the board-level display pins (or a loopback of the display driver) and self-check/readback logic.
//  Rejects mux-transition ghosting with a per-digit stability filter; publishes a frame atomically with a strobe.
// PARAMETERS
//  NUM_DIGITS     4    digits on the multiplexed bus (1..8)
//  STABLE_CYCLES  16   consecutive identical samples required before a digit is accepted (2..255)
// PORTS
//  clk          in   1             single clock; all logic on rising edge
//  rst          in   1             asynchronous, active-high reset
//  seg_n        in   8             segments, active-low: [7]=dp, [6:0]=g..a
//  dig_en_n     in   NUM_DIGITS    digit enables, active-low, expected one-hot-low
//  bcd_out      out  4*NUM_DIGITS  captured frame, digit i at [4i+3:4i]
//  dp_out       out  NUM_DIGITS    captured decimal points, 1 = lit
//  frame_valid  out  1             one-cycle pulse when bcd_out/dp_out update
//  pat_err      out  1             one-cycle pulse when an accepted pattern is not a legal glyph
// BEHAVIOUR
//  - Inputs registered in two flops (sync); all decisions use the second stage. Latency pin->decision = 2 cycles.
//  - Reset: bcd_out=0, dp_out=0, frame_valid=0, pat_err=0, FSM=WAIT, counter=0, seen mask=0, shadow regs=0.
//  - Legal glyphs on seg_n[6:0]: 0=40 1=79 2=24 3=30 4=19 5=12 6=03 7=78 8=00 9=18 (hex). dp ignored for lookup.
//  - FSM WAIT: dig_en_n not exactly one bit low -> stay; exactly one low -> latch index+pattern, cnt=1, go SETTLE.
//  - SETTLE: same index and same 8-bit pattern -> cnt++; cnt reaches STABLE_CYCLES -> accept, go HOLD.
//    Any change of index or pattern -> reload with new sample (cnt=1) or go WAIT if enables not one-hot.
//  - Accept: legal glyph -> shadow[idx]=digit, shadow_dp[idx]=~seg_n[7], seen[idx]=1. Illegal -> pat_err pulse,
//    shadow and seen untouched.
//  - HOLD: no re-accept while index and pattern unchanged; any change handled as in SETTLE. A digit is
//    accepted at most once per enable window.
//  - Frame: cycle after seen becomes all-ones: bcd_out/dp_out <= shadow, frame_valid=1, seen cleared.
//    A later digit's accept in the same cycle as the frame publish sets its seen bit for the next frame.
//  - Same-digit re-accept before frame completes overwrites shadow (latest value wins).
//  - Counter saturates at STABLE_CYCLES; no wrap. Width = clog2(STABLE_CYCLES+1).
//  - Reset asserted mid-frame discards partial frame; outputs return to reset values immediately (async).
//  - frame_valid and pat_err never both depend on the same accept; they may coincide only from different events.
// CONFIGURATION
//  SEG7_CAPTURE_BLANK_EN defined: pattern 7F (all segments off) is legal, captured as 4'hF (blank digit).
//  Not defined: 7F is illegal -> pat_err pulse, digit not marked seen (frame stalls until a lit glyph).
// STRUCTURE
//  seg7_pkg: glyph constants (SEG7_GLYPH_0..9, SEG7_BLANK=7'h7F), BCD_BLANK=4'hF, FSM state typedef
//  {WAIT, SETTLE, HOLD}.
//  Sub-module seg7_pattern_decode: combinational 7-bit pattern -> {legal, digit[3:0]}; honours the blank macro.
//  Top holds sync flops, FSM, stability counter, shadow/seen registers, output registers.
// TESTING
//  1. NUM_DIGITS=4; scan digits 0..3 with seg_n 0xF9,0xA4,0xB0,0x19, 20 cycles each -> frame_valid once,
//     bcd_out=16'h4321, dp_out=4'b1000.
//  2. 3-cycle glitch pattern 0x80 at each enable edge before the real glyph -> glitch never captured,
//     pat_err stays 0, frame equals the real glyphs.
//  3. seg_n=0xFF (blank) on digit 2 -> with SEG7_CAPTURE_BLANK_EN: nibble 2 = F, frame issued;
//     without: pat_err pulse, no frame_valid until a legal glyph.
//  4. seg_n=0x8C (illegal) held 20 cycles on digit 1 -> exactly one pat_err pulse; bcd_out unchanged.
//  5. dig_en_n=4'b0011 (two low) for 40 cycles -> no accept, FSM in WAIT, no pulses.
//  6. Pattern held exactly STABLE_CYCLES-1 then changed -> no accept; assert rst after 3 of 4 digits ->
//     outputs 0, following full scan yields one frame with only new values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: glyph encodings,
// blank codes and the capture FSM state type.
// Glyphs are active-low segment patterns on g..a (bit 6..0).
package seg7_pkg;

   localparam logic [6:0] SEG7_GLYPH_0 = 7'h40;
   localparam logic [6:0] SEG7_GLYPH_1 = 7'h79;
   localparam logic [6:0] SEG7_GLYPH_2 = 7'h24;
   localparam logic [6:0] SEG7_GLYPH_3 = 7'h30;
   localparam logic [6:0] SEG7_GLYPH_4 = 7'h19;
   localparam logic [6:0] SEG7_GLYPH_5 = 7'h12;
   localparam logic [6:0] SEG7_GLYPH_6 = 7'h03;
   localparam logic [6:0] SEG7_GLYPH_7 = 7'h78;
   localparam logic [6:0] SEG7_GLYPH_8 = 7'h00;
   localparam logic [6:0] SEG7_GLYPH_9 = 7'h18;
   localparam logic [6:0] SEG7_BLANK   = 7'h7F;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose : combinational 7-segment pattern (active-low g..a) -> {legal, BCD digit}.
// Ports   : pattern[6:0] in; legal out (1 = recognised glyph); digit[3:0] out (0 when illegal).
// Config  : SEG7_CAPTURE_BLANK_EN makes the all-off pattern legal and decodes it as BCD_BLANK.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       legal,
   output logic [3:0] digit
);

   always_comb begin
      legal = 1'b1;
      digit = 4'd0;
      case (pattern)
         SEG7_GLYPH_0: digit = 4'd0;
         SEG7_GLYPH_1: digit = 4'd1;
         SEG7_GLYPH_2: digit = 4'd2;
         SEG7_GLYPH_3: digit = 4'd3;
         SEG7_GLYPH_4: digit = 4'd4;
         SEG7_GLYPH_5: digit = 4'd5;
         SEG7_GLYPH_6: digit = 4'd6;
         SEG7_GLYPH_7: digit = 4'd7;
         SEG7_GLYPH_8: digit = 4'd8;
         SEG7_GLYPH_9: digit = 4'd9;
`ifdef SEG7_CAPTURE_BLANK_EN
         SEG7_BLANK:   digit = BCD_BLANK;
`else
         // A dark digit is treated as an error so a frame never completes with it.
         SEG7_BLANK: begin
            legal = 1'b0;
            digit = 4'd0;
         end
`endif
         default: begin
            legal = 1'b0;
            digit = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Purpose : receive side of a multiplexed 7-segment bus; filters each digit window for
//           stability, decodes it to BCD + dp and publishes whole frames with a strobe.
// Ports   : clk, rst (async active-high); seg_n[7:0] (dp,g..a active-low); dig_en_n[N-1:0]
//           (active-low one-hot); bcd_out[4N-1:0], dp_out[N-1:0], frame_valid, pat_err pulses.
// Config  : SEG7_CAPTURE_BLANK_EN (see seg7_pattern_decode) accepts all-off as a blank digit.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_en_n,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic                    frame_valid,
   output logic                    pat_err
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Two-stage input synchroniser; every decision uses the second stage.
   logic [7:0]            seg_s1, seg_s2;
   logic [NUM_DIGITS-1:0] en_s1, en_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1 <= 8'hFF;
         seg_s2 <= 8'hFF;
         en_s1  <= '1;
         en_s2  <= '1;
      end else begin
         seg_s1 <= seg_n;
         seg_s2 <= seg_s1;
         en_s1  <= dig_en_n;
         en_s2  <= en_s1;
      end
   end

   // Enable decode: count low enables and remember which one was low.
   logic [3:0]       low_cnt;
   logic [IDX_W-1:0] samp_idx;
   logic             samp_one_hot;

   always_comb begin
      low_cnt  = 4'd0;
      samp_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!en_s2[i]) begin
            low_cnt  = low_cnt + 4'd1;
            samp_idx = IDX_W'(i);
         end
      end
      samp_one_hot = (low_cnt == 4'd1);
   end

   // Capture FSM: state, latched window index/pattern, stability counter.
   cap_state_t       state, state_nxt;
   logic [IDX_W-1:0] cur_idx, idx_nxt;
   logic [7:0]       cur_pat, pat_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept;
   logic             same_sample;

   assign same_sample = samp_one_hot && (samp_idx == cur_idx) && (seg_s2 == cur_pat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WAIT;
         cur_idx <= '0;
         cur_pat <= 8'h00;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         cur_idx <= idx_nxt;
         cur_pat <= pat_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = cur_idx;
      pat_nxt   = cur_pat;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         WAIT: begin
            if (samp_one_hot) begin
               state_nxt = SETTLE;
               idx_nxt   = samp_idx;
               pat_nxt   = seg_s2;
               cnt_nxt   = CNT_ONE;
            end
         end
         SETTLE, HOLD: begin
            if (!samp_one_hot) begin
               state_nxt = WAIT;
               cnt_nxt   = '0;
            end else if (!same_sample) begin
               // New window or new pattern: restart the stability count on it.
               state_nxt = SETTLE;
               idx_nxt   = samp_idx;
               pat_nxt   = seg_s2;
               cnt_nxt   = CNT_ONE;
            end else if (state == SETTLE) begin
               if (cnt == CNT_MAX - CNT_ONE) begin
                  cnt_nxt   = CNT_MAX;
                  accept    = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            // HOLD with an unchanged sample: counter stays saturated, no re-accept.
         end
         default: begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // The accepted sample equals cur_pat, so decode the latched copy.
   logic       dec_legal;
   logic [3:0] dec_digit;

   seg7_pattern_decode u_decode (
      .pattern (cur_pat[6:0]),
      .legal   (dec_legal),
      .digit   (dec_digit)
   );

   // Shadow frame and per-digit seen mask.
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [NUM_DIGITS-1:0]   seen, seen_nxt;
   logic                    seen_full;
   logic                    good_accept;

   assign seen_full   = &seen;
   assign good_accept = accept && dec_legal;

   // Publishing clears the mask, but an accept landing on the same edge already
   // counts towards the next frame.
   always_comb begin
      seen_nxt = seen_full ? '0 : seen;
      if (good_accept) begin
         seen_nxt[cur_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow      <= '0;
         shadow_dp   <= '0;
         seen        <= '0;
         bcd_out     <= '0;
         dp_out      <= '0;
         frame_valid <= 1'b0;
         pat_err     <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         pat_err     <= 1'b0;
         seen        <= seen_nxt;
         if (seen_full) begin
            bcd_out     <= shadow;
            dp_out      <= shadow_dp;
            frame_valid <= 1'b1;
         end
         if (good_accept) begin
            shadow[{cur_idx, 2'b00} +: 4] <= dec_digit;
            shadow_dp[cur_idx]            <= ~cur_pat[7];
         end
         if (accept && !dec_legal) begin
            pat_err <= 1'b1;
         end
      end
   end

endmodule
